// File: rtl/rdmap_hdr_gen_q_if.sv
// rdmap_hdr_gen_q_if
// Bundles the request side (decoder -> generator), the buffer-pool side and
// the DDP side of the RDMAP header generator.
//   master : environment view (drives requests, pool status, DDP ready)
//   slave  : header generator view
// Signals:
//   infoValid/infoReady       request handshake
//   rdmaControl, rdmaWR       control word and work request
//   rgstrPtr, poolFull        buffer-register pointer and pool status
//   bufRegister, rgstrNum     one-cycle buffer registration request
//   rdmap2DdpHeader/Ctrl      FIFO head header and opcode
//   rdmap2DdpHdrValid/Ready   DDP pop handshake
//   unknownOpCnt              saturating unknown-opcode count
`timescale 1ns/1ps
interface rdmap_hdr_gen_q_if #(
  parameter int WR_W   = 52,
  parameter int CTRL_W = 16,
  parameter int HDR_W  = 56,
  parameter int PTR_W  = 5
);
  logic              infoValid;
  logic              infoReady;
  logic [CTRL_W-1:0] rdmaControl;
  logic [WR_W-1:0]   rdmaWR;
  logic [PTR_W-1:0]  rgstrPtr;
  logic              poolFull;
  logic              bufRegister;
  logic [2:0]        rgstrNum;
  logic [HDR_W-1:0]  rdmap2DdpHeader;
  logic [7:0]        rdmap2DdpCtrl;
  logic              rdmap2DdpHdrValid;
  logic              rdmap2DdpHdrReady;
  logic [7:0]        unknownOpCnt;

  modport master (
    output infoValid, rdmaControl, rdmaWR, rgstrPtr, poolFull, rdmap2DdpHdrReady,
    input  infoReady, bufRegister, rgstrNum, rdmap2DdpHeader, rdmap2DdpCtrl,
           rdmap2DdpHdrValid, unknownOpCnt
  );

  modport slave (
    input  infoValid, rdmaControl, rdmaWR, rgstrPtr, poolFull, rdmap2DdpHdrReady,
    output infoReady, bufRegister, rgstrNum, rdmap2DdpHeader, rdmap2DdpCtrl,
           rdmap2DdpHdrValid, unknownOpCnt
  );
endinterface

// File: rtl/rdmap_hdr_gen_q.sv
// rdmap_hdr_gen_q
// RDMAP header generator. Takes one work request per handshake, formats a
// DDP header according to the opcode, requests buffer registration for ACKs
// and queues the headers in a show-ahead FIFO towards the DDP layer.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    rdmap_hdr_gen_q_if.slave (request, pool, DDP and status signals)
`timescale 1ns/1ps
module rdmap_hdr_gen_q #(
  parameter int WR_W       = 52,
  parameter int CTRL_W     = 16,
  parameter int HDR_W      = 56,
  parameter int QN_CNT     = 4,
  parameter int QN_W       = 4,
  parameter int PTR_W      = 5,
  parameter int RGN_LSB    = 44,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  rdmap_hdr_gen_q_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // RCV, REQ and unknown share the raw format; unknown is kept apart so it
  // can be counted.
  typedef enum logic [1:0] {
    CLS_RAW,
    CLS_SEND,
    CLS_ACK,
    CLS_UNKNOWN
  } opClass_e;

  logic            s1Valid_q;
  logic [7:0]      s1Ctrl_q;
  logic [WR_W-1:0] s1Wr_q;
  opClass_e        s1Class_q;
  logic [QN_W-1:0] s1Ptr_q;

  logic [HDR_W-1:0] hdrMem [FIFO_DEPTH];
  logic [7:0]       ctrlMem [FIFO_DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q, count_d;
  logic [HDR_W-1:0] lastHdr_q;
  logic [7:0]       lastCtrl_q;
  logic [7:0]       unknownCnt_q, unknownCnt_d;

  opClass_e         opClass;
  logic [HDR_W-1:0] fmtHdr;
  logic [AW+1:0]    slotsUsed;
  logic             readyInt, accept, push, pop, headValid;
  logic             unusedBits;

  assign unusedBits = ^{bus.rdmaControl[CTRL_W-1:8], bus.rgstrPtr[PTR_W-1:QN_W]};

  // Credit uses only registered occupancy, so a pop in the same cycle does
  // not open a slot until the next cycle.
  assign slotsUsed = {1'b0, count_q} + (AW+2)'(s1Valid_q);
  assign readyInt  = !reset && !bus.poolFull && (slotsUsed < (AW+2)'(FIFO_DEPTH));
  assign accept    = bus.infoValid && readyInt;
  assign push      = s1Valid_q;
  assign headValid = (count_q != '0);
  assign pop       = headValid && bus.rdmap2DdpHdrReady;

  // Opcode decode of the incoming control word.
  always_comb begin
    opClass = CLS_UNKNOWN;
    case (bus.rdmaControl[7:0])
      8'h00:        opClass = CLS_SEND;
      8'h01, 8'h03: opClass = CLS_RAW;
      8'h07:        opClass = CLS_ACK;
      default:      opClass = CLS_UNKNOWN;
    endcase
  end

  // Stage S1: capture the accepted request and a snapshot of the pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s1Ctrl_q  <= '0;
      s1Wr_q    <= '0;
      s1Class_q <= CLS_RAW;
      s1Ptr_q   <= '0;
    end else begin
      s1Valid_q <= accept;
      if (accept) begin
        s1Ctrl_q  <= bus.rdmaControl[7:0];
        s1Wr_q    <= bus.rdmaWR;
        s1Class_q <= opClass;
        s1Ptr_q   <= bus.rgstrPtr[QN_W-1:0];
      end
    end
  end

  // Header formatting; ACK queue numbers are consecutive from the pointer
  // snapshot, wrapping at the queue-number width, QN0 most significant.
  always_comb begin
    fmtHdr = '0;
    case (s1Class_q)
      CLS_ACK: begin
        fmtHdr[HDR_W-1 -: 16] = s1Wr_q[WR_W-1 -: 16];
        for (int i = 0; i < QN_CNT; i++) begin
          fmtHdr[HDR_W-17-i*QN_W -: QN_W] = s1Ptr_q + QN_W'(i);
        end
      end
      CLS_SEND: fmtHdr[HDR_W-1 -: 8]    = s1Wr_q[WR_W-9 -: 8];
      default:  fmtHdr[HDR_W-1 -: WR_W] = s1Wr_q;
    endcase
  end

  assign bus.bufRegister = s1Valid_q && (s1Class_q == CLS_ACK);
  assign bus.rgstrNum    = bus.bufRegister ? s1Wr_q[RGN_LSB +: 3] : 3'd0;

  // Unknown-opcode counter sticks at 255.
  always_comb begin
    unknownCnt_d = unknownCnt_q;
    if (s1Valid_q && (s1Class_q == CLS_UNKNOWN) && (unknownCnt_q != 8'hFF)) begin
      unknownCnt_d = unknownCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) unknownCnt_q <= '0;
    else       unknownCnt_q <= unknownCnt_d;
  end

  // FIFO storage needs no reset: the count gates what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      hdrMem[wrPtr_q]  <= fmtHdr;
      ctrlMem[wrPtr_q] <= s1Ctrl_q;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since the depth is a power of two. The last
  // popped entry is kept so the outputs hold while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      lastHdr_q  <= '0;
      lastCtrl_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop) begin
        rdPtr_q    <= rdPtr_q + AW'(1);
        lastHdr_q  <= hdrMem[rdPtr_q];
        lastCtrl_q <= ctrlMem[rdPtr_q];
      end
    end
  end

  assign bus.infoReady         = readyInt;
  assign bus.rdmap2DdpHdrValid = headValid;
  assign bus.rdmap2DdpHeader   = headValid ? hdrMem[rdPtr_q]  : lastHdr_q;
  assign bus.rdmap2DdpCtrl     = headValid ? ctrlMem[rdPtr_q] : lastCtrl_q;
  assign bus.unknownOpCnt      = unknownCnt_q;

endmodule

// File: doc/rdmap_hdr_gen_q.md
Name: rdmap_hdr_gen_q

Overview:
- Parametrised RDMAP header generator between the RDMA operation decoder and the DDP layer.
- Accepts one work request (control word + WR) per valid/ready handshake and formats the DDP header by opcode.
- For ACK, embeds QN_CNT consecutive buffer-register queue numbers and requests buffer registration.
- Queues formatted headers in an output FIFO with DDP-side backpressure, and counts unknown opcodes.

Parameters:
- WR_W, 52, work-request width.
- CTRL_W, 16, control word width; opcode is rdmaControl[7:0].
- HDR_W, 56, header width; must satisfy HDR_W >= WR_W and HDR_W >= 16+QN_CNT*QN_W.
- QN_CNT, 4, queue numbers embedded in an ACK header (1..8).
- QN_W, 4, width of each queue number.
- PTR_W, 5, register-pointer width (PTR_W >= QN_W).
- RGN_LSB, 44, LSB of the 3-bit register number inside the WR.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- infoValid  in  1  request valid
- infoReady  out  1  request accepted when infoValid & infoReady
- rdmaControl  in  CTRL_W  control word
- rdmaWR  in  WR_W  work request
- rgstrPtr  in  PTR_W  current buffer-register pointer
- poolFull  in  1  buffer pool full
- bufRegister  out  1  one-cycle buffer-registration request
- rgstrNum  out  3  register number qualified by bufRegister
- rdmap2DdpHeader  out  HDR_W  FIFO head header
- rdmap2DdpCtrl  out  8  FIFO head opcode/control
- rdmap2DdpHdrValid  out  1  FIFO head valid
- rdmap2DdpHdrReady  in  1  DDP pops when valid & ready
- unknownOpCnt  out  8  saturating unknown-opcode count

Behaviour:
- Opcodes: SEND=8'h00, RCV=8'h01, REQ=8'h03, ACK=8'h07; any other value is unknown.
- infoReady = !poolFull && (fifoCount + s1Valid) < FIFO_DEPTH.
  - Uses registered state only; no same-cycle pop credit.
  - Does not depend on infoValid.
- Stage S1, accept at cycle N:
  - Register control, WR, opcode class, and rgstrPtr snapshot.
  - Set s1Valid.
- Stage S1 output, cycle N+1:
  - Push formatted header and ctrl[7:0] into the FIFO.
  - If an ACK, assert bufRegister=1 and rgstrNum = WR[RGN_LSB+2:RGN_LSB] for exactly this cycle.
  - If unknown, increment unknownOpCnt, saturating at 255.
- Header formats:
  - ACK: {WR[WR_W-1:WR_W-16], QN0..QN(QN_CNT-1), zero-fill}, with QN0 in the most significant position. QNi = (ptr[QN_W-1:0] + i) mod 2^QN_W; wraps, e.g. ptr=4'hE gives E,F,0,1.
  - SEND: {WR[WR_W-9:WR_W-16], zero-fill}.
  - RCV, REQ, unknown: {WR, zero-fill}.
- FIFO: show-ahead.
  - Head is visible at N+2 when the FIFO was empty, so accept-to-valid latency is 2.
  - Push and pop in the same cycle: count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - When rdmap2DdpHdrValid is low, header/ctrl hold their last value, or 0 after reset.
- Throughput: one request per cycle sustained while rdmap2DdpHdrReady=1 and FIFO_DEPTH >= 3.
- poolFull high: infoReady deasserts regardless of opcode. An already-accepted S1 entry still completes.
- Reset (any cycle, including mid-stream):
  - Next edge clears FIFO, s1Valid and the counter; in-flight data is discarded.
  - Outputs: infoReady=0 during reset, 1 in the first cycle after.
  - bufRegister=0, rgstrNum=0, rdmap2DdpHdrValid=0, header=0, ctrl=0, unknownOpCnt=0.
- Unused WR/control bits are ignored.

Test Plan:
- Single ACK, WR[51:36]=16'hA5C3, WR[46:44]=3'd5, rgstrPtr=5'h0E, defaults:
  - bufRegister pulse at N+1 with rgstrNum=5.
  - Header 56'hA5C3_EF01_000000 valid at N+2.
  - ctrl=8'h07.
- SEND with WR[43:36]=8'h3C → header 56'h3C_0000_0000_0000. RCV with WR=52'h123456789ABCD → header 56'h123456789ABCD_0.
- Back-to-back 8 requests, ready held 0:
  - Exactly FIFO_DEPTH=4 accepted; infoReady low after the 4th.
  - Raise ready: all 4 emerge in order, then the remaining 4 flow with no bubbles.
- poolFull=1 for 3 cycles while infoValid=1:
  - No accepts, no bufRegister.
  - Accept on the first cycle after poolFull drops.
- 300 requests with opcode 8'h55 → unknownOpCnt saturates at 255; headers still forwarded in default format.
- Assert reset with 3 entries queued and S1 full:
  - Next cycle valid=0 and counter=0.
  - No stale header appears after reset release.
